// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/sub/compare engine.
//   DEF_NIBBLES : default number of 4-bit slices per word
//   op_e        : operation codes presented on i_op
//   state_e     : controller states
package alu_seq_ctrl_pkg;

   localparam int unsigned DEF_NIBBLES = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_CMP = 2'b10,
      OP_ADC = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // SUB and CMP both drive the slice in subtract mode
   function automatic logic is_sub(input op_e op);
      return (op == OP_SUB) || (op == OP_CMP);
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu4_slice.sv
// Combinational 4-bit add/subtract slice.
//   i_x, i_y : operands (i_y is inverted when i_sub=1)
//   i_sub    : subtract mode
//   i_ci     : carry in, kept separate from i_sub so nibbles can be chained
//   o_sum_c  : 4-bit sum
//   o_co_c   : carry out
module alu4_slice (
   input  logic [3:0] i_x,
   input  logic [3:0] i_y,
   input  logic       i_sub,
   input  logic       i_ci,
   output logic [3:0] o_sum_c,
   output logic       o_co_c
);

   logic [3:0] w_my;
   logic [4:0] w_total;

   assign w_my    = i_y ^ {4{i_sub}};
   assign w_total = 5'(i_x) + 5'(w_my) + 5'(i_ci);
   assign {o_co_c, o_sum_c} = w_total;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle W-bit add/sub/compare engine using one shared 4-bit slice
// over NIBBLES cycles, with a start/busy/done handshake.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : request, sampled only in IDLE
//   i_op         : 00 ADD, 01 SUB, 10 CMP, 11 ADC
//   i_a, i_b     : operands, latched on acceptance
//   o_busy       : nibbles being computed
//   o_done       : one-cycle completion pulse
//   o_result     : last ADD/SUB/ADC result
//   o_cf/of/zf/sf: carry(borrow)/overflow/zero/sign flags of last completion
module alu_seq_ctrl
   import alu_seq_ctrl_pkg::*;
#(
   parameter int unsigned NIBBLES = DEF_NIBBLES
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [1:0]         i_op,
   input  logic [4*NIBBLES-1:0] i_a,
   input  logic [4*NIBBLES-1:0] i_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [4*NIBBLES-1:0] o_result,
   output logic               o_cf,
   output logic               o_of,
   output logic               o_zf,
   output logic               o_sf
);

   localparam int unsigned W     = 4 * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_e             r_state;
   state_e             w_next_state;
   logic               w_accept;
   logic               w_finish;
   logic               w_c0;

   logic [IDX_W-1:0]   r_idx;
   op_e                r_op;
   logic               r_sub;
   logic               r_carry;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_psum;
   logic [W-1:0]       w_sum_full;

   logic [3:0]         w_slice_sum;
   logic               w_slice_co;
   logic               w_last;

   // Operands for the nibble currently being computed; carry register
   // already holds c0 at idx 0, so ci is always taken from it.
   alu4_slice u_slice (
      .i_x     (r_a[{r_idx, 2'b00} +: 4]),
      .i_y     (r_b[{r_idx, 2'b00} +: 4]),
      .i_sub   (r_sub),
      .i_ci    (r_carry),
      .o_sum_c (w_slice_sum),
      .o_co_c  (w_slice_co)
   );

   assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

   // Partial sum with the current nibble merged in; complete on the last nibble
   always_comb begin
      w_sum_full = r_psum;
      w_sum_full[{r_idx, 2'b00} +: 4] = w_slice_sum;
   end

   // Carry-in for nibble 0
   always_comb begin
      w_c0 = 1'b0;
      case (op_e'(i_op))
         OP_SUB, OP_CMP: w_c0 = 1'b1;
         OP_ADC:         w_c0 = o_cf;
         default:        w_c0 = 1'b0;
      endcase
   end

   // Next-state and control strobes
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next_state = S_RUN;
               w_accept     = 1'b1;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_next_state = S_DONE;
               w_finish     = 1'b1;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Datapath, handshake and flag registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx    <= '0;
         r_op     <= OP_ADD;
         r_sub    <= 1'b0;
         r_carry  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_psum   <= '0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_result <= '0;
         o_cf     <= 1'b0;
         o_of     <= 1'b0;
         o_zf     <= 1'b0;
         o_sf     <= 1'b0;
      end else begin
         o_busy <= (w_next_state == S_RUN);
         o_done <= (w_next_state == S_DONE);
         if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_op    <= op_e'(i_op);
            r_sub   <= is_sub(op_e'(i_op));
            r_carry <= w_c0;
            r_idx   <= '0;
            r_psum  <= '0;
         end else if (r_state == S_RUN) begin
            r_psum  <= w_sum_full;
            r_carry <= w_slice_co;
            r_idx   <= w_finish ? '0 : r_idx + IDX_W'(1);
            if (w_finish) begin
               if (r_op != OP_CMP) o_result <= w_sum_full;
               o_cf <= w_slice_co ^ r_sub;
               o_of <= (r_a[W-1] == (r_b[W-1] ^ r_sub)) &&
                       (w_sum_full[W-1] != r_a[W-1]);
               o_zf <= ~|w_sum_full;
               o_sf <= w_sum_full[W-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [15:0] a, b;
   logic        busy, done, cf, of, zf, sf;
   logic [15:0] result;

   int errors = 0;
   int checks = 0;

   // Reference state: flags/result of the last completion
   logic [15:0] m_result;
   logic        m_cf, m_of, m_zf, m_sf;

   alu_seq_ctrl #(.NIBBLES(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
      .i_a(a), .i_b(b),
      .o_busy(busy), .o_done(done), .o_result(result),
      .o_cf(cf), .o_of(of), .o_zf(zf), .o_sf(sf)
   );

   always #5 clk = ~clk;

   // Issue one operation, check handshake timing and final outputs.
   // Called at #1 after an edge with the DUT idle or in its done cycle.
   task automatic run_op(input logic [1:0] t_op, input logic [15:0] t_a,
                         input logic [15:0] t_b, input bit pulses, input string tag);
      logic [16:0] u;
      int          sa, sb, full;
      logic [15:0] e_res;
      logic        e_cf, e_of, e_zf, e_sf;
      bit          got;
      sa = int'($signed(t_a));
      sb = int'($signed(t_b));
      case (t_op)
         2'd0:    begin u = 17'(t_a) + 17'(t_b);               full = sa + sb; end
         2'd3:    begin u = 17'(t_a) + 17'(t_b) + 17'(m_cf);   full = sa + sb + int'(m_cf); end
         default: begin u = 17'(t_a) - 17'(t_b);               full = sa - sb; end
      endcase
      e_cf  = u[16];
      e_of  = (full > 32767) || (full < -32768);
      e_zf  = (u[15:0] == 16'h0000);
      e_sf  = u[15];
      e_res = (t_op == 2'd2) ? m_result : u[15:0];

      op = t_op; a = t_a; b = t_b; start = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
         @(posedge clk); #1;
         if (busy === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s accept: busy=%b required 1 within 4 cycles", tag, busy);
         start = 1'b0;
         return;
      end
      // Operands may change freely after acceptance
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         if (cyc > 1) begin @(posedge clk); #1; end
         start = pulses && (cyc == 2 || cyc == 4);
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s run_cycle%0d: busy=%b done=%b required busy=1 done=0",
                     tag, cyc, busy, done);
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL %s done_cycle: busy=%b done=%b required busy=0 done=1", tag, busy, done);
      end
      checks++;
      if (result !== e_res) begin
         errors++;
         $display("FAIL %s result: got %h required %h", tag, result, e_res);
      end
      checks++;
      if ({cf, of, zf, sf} !== {e_cf, e_of, e_zf, e_sf}) begin
         errors++;
         $display("FAIL %s flags cf/of/zf/sf: got %b%b%b%b required %b%b%b%b",
                  tag, cf, of, zf, sf, e_cf, e_of, e_zf, e_sf);
      end
      m_result = e_res; m_cf = e_cf; m_of = e_of; m_zf = e_zf; m_sf = e_sf;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; op = 2'd0; a = 16'h1111; b = 16'h2222;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if ({busy, done, result, cf, of, zf, sf} !== 22'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b result=%h flags=%b%b%b%b required all 0",
                  busy, done, result, cf, of, zf, sf);
      end
      rst = 1'b0; start = 1'b0;
      m_result = '0; m_cf = 0; m_of = 0; m_zf = 0; m_sf = 0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_directed();
      run_op(2'd0, 16'h1234, 16'h0FFF, 0, "add_basic");
      checks++;
      if ({result, cf, of, zf, sf} !== {16'h2233, 4'b0000}) begin
         errors++;
         $display("FAIL add_basic_const: got %h/%b%b%b%b required 2233/0000", result, cf, of, zf, sf);
      end
      @(posedge clk); #1;
      run_op(2'd1, 16'h8000, 16'h0001, 0, "sub_ovf");
      checks++;
      if ({result, cf, of, zf, sf} !== {16'h7FFF, 4'b0100}) begin
         errors++;
         $display("FAIL sub_ovf_const: got %h/%b%b%b%b required 7fff/0100", result, cf, of, zf, sf);
      end
      @(posedge clk); #1;
      run_op(2'd1, 16'h0001, 16'h0002, 0, "sub_borrow");
      checks++;
      if ({result, cf, of, sf} !== {16'hFFFF, 3'b101}) begin
         errors++;
         $display("FAIL sub_borrow_const: got %h cf=%b of=%b sf=%b required ffff 1 0 1", result, cf, of, sf);
      end
      @(posedge clk); #1;
      run_op(2'd0, 16'hFFFF, 16'h0001, 0, "add_wrap");
      checks++;
      if ({result, cf, zf, of} !== {16'h0000, 3'b110}) begin
         errors++;
         $display("FAIL add_wrap_const: got %h cf=%b zf=%b of=%b required 0000 1 1 0", result, cf, zf, of);
      end
      @(posedge clk); #1;
      run_op(2'd3, 16'h0000, 16'h0000, 0, "adc_carry");
      checks++;
      if ({result, cf, zf} !== {16'h0001, 2'b00}) begin
         errors++;
         $display("FAIL adc_carry_const: got %h cf=%b zf=%b required 0001 0 0", result, cf, zf);
      end
      @(posedge clk); #1;
      run_op(2'd2, 16'h5555, 16'h5555, 0, "cmp_equal");
      checks++;
      if ({result, zf, cf, sf} !== {16'h0001, 3'b100}) begin
         errors++;
         $display("FAIL cmp_equal_const: got %h zf=%b cf=%b sf=%b required 0001 1 0 0", result, zf, cf, sf);
      end
   endtask

   task automatic test_ignore_start();
      @(posedge clk); #1;
      run_op(2'd0, 16'h00F0, 16'h0F0F, 1, "ignore_start");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_after%0d: busy=%b done=%b required 0 0", k, busy, done);
         end
      end
   endtask

   task automatic test_reset_abort();
      op = 2'd1; a = 16'h4321; b = 16'h1234; start = 1'b1;
      @(posedge clk); #1;   // accepted, idx=0
      start = 1'b0;
      @(posedge clk); #1;   // idx=1
      @(posedge clk); #1;   // idx=2
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({busy, done, result, cf, of, zf, sf} !== 22'd0) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b result=%h flags=%b%b%b%b required all 0",
                  busy, done, result, cf, of, zf, sf);
      end
      m_result = '0; m_cf = 0; m_of = 0; m_zf = 0; m_sf = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done%0d: busy=%b done=%b required 0 0", k, busy, done);
         end
      end
      run_op(2'd0, 16'h0001, 16'h0001, 0, "after_abort");
      checks++;
      if (result !== 16'h0002) begin
         errors++;
         $display("FAIL after_abort_const: got %h required 0002", result);
      end
   endtask

   // Consecutive operations with start re-asserted during the done cycle
   task automatic test_back_to_back();
      logic [1:0]  r_op;
      logic [15:0] r_a, r_b;
      for (int n = 0; n < 50; n++) begin
         r_op = 2'($urandom);
         r_a  = 16'($urandom);
         r_b  = 16'($urandom);
         case ($urandom_range(0, 5))
            0: r_a = 16'hFFFF;
            1: r_b = 16'h8000;
            2: r_b = r_a;
            3: r_a = 16'h7FFF;
            default: ;
         endcase
         run_op(r_op, r_a, r_b, 0, $sformatf("rand%0d", n));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      #1;
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
